// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: state encoding, parity
// selectors and serial line levels.
package uart_tx_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned SER_W    = 8;

    // State encoding
    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] START  = 3'd1;
    localparam logic [STATE_W-1:0] DATA   = 3'd2;
    localparam logic [STATE_W-1:0] PARITY = 3'd3;
    localparam logic [STATE_W-1:0] STOP   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = IDLE,
        ST_START  = START,
        ST_DATA   = DATA,
        ST_PARITY = PARITY,
        ST_STOP   = STOP
    } tx_state_e;

    // Parity type selectors
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Serial line levels
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of the parallel word.
// Ports:
//   P_DATA     in  word to protect
//   PAR_TYP    in  0 = even, 1 = odd
//   par_bit_c  out parity bit to place on the line
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SER_W
) (
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_TYP,
    output logic                  par_bit_c
);

    // XOR-reduce gives even parity; odd type inverts it
    assign par_bit_c = (^P_DATA) ^ (PAR_TYP == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// Frame controller for the UART transmit path around an 8-bit serializer.
// Sequences start -> data -> optional parity -> stop and muxes TX_OUT.
// Ports:
//   CLK, RST     bit clock, async active-low reset
//   P_DATA       parallel word (parity only; serializer shifts the data)
//   Data_Valid   upstream word valid
//   PAR_EN       insert parity bit
//   PAR_TYP      0 = even, 1 = odd
//   ser_data     serializer bit, registered, LSB first
//   ser_done     serializer has shifted all bits
//   ser_en       serializer shift enable
//   accept_new   word taken when Data_Valid && accept_new
//   TX_OUT       serial line
//   busy         frame in progress
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SER_W,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  accept_new,
    output logic                  TX_OUT,
    output logic                  busy
);

    tx_state_e state_q, state_d;
    logic      stop_cnt_q;
    logic      par_en_q;
    logic      par_bit_q;
    logic      par_bit_c;
    logic      last_stop_c;
    logic      accept_c;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .P_DATA    (P_DATA),
        .PAR_TYP   (PAR_TYP),
        .par_bit_c (par_bit_c)
    );

    // Final stop bit is the only point inside a frame that may take a new word
    assign last_stop_c = (state_q == ST_STOP) && (stop_cnt_q == 1'(STOP_BITS - 1));
    assign accept_c    = Data_Valid && accept_new;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop-bit counter; held at zero outside STOP
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stop_cnt_q <= 1'b0;
        end else if ((state_q == ST_STOP) && !last_stop_c) begin
            stop_cnt_q <= stop_cnt_q + 1'b1;
        end else begin
            stop_cnt_q <= 1'b0;
        end
    end

    // Per-frame configuration captured at acceptance
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept_c) begin
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit_c;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        TX_OUT     = LINE_IDLE;
        busy       = 1'b0;
        ser_en     = 1'b0;
        accept_new = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                accept_new = 1'b1;
                if (Data_Valid) state_d = ST_START;
            end
            ST_START: begin
                TX_OUT  = START_BIT;
                busy    = 1'b1;
                ser_en  = 1'b1;     // preload bit0 so it is on ser_data in the first DATA cycle
                state_d = ST_DATA;
            end
            ST_DATA: begin
                TX_OUT = ser_data;
                busy   = 1'b1;
                ser_en = !ser_done;
                if (ser_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                TX_OUT  = par_bit_q;
                busy    = 1'b1;
                state_d = ST_STOP;
            end
            ST_STOP: begin
                TX_OUT = STOP_BIT;
                busy   = 1'b1;
                if (last_stop_c) begin
                    accept_new = 1'b1;
                    state_d    = Data_Valid ? ST_START : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: one instance per stop-bit setting, each with a
// behavioural serializer, checked cycle by cycle against a frame-bit model.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;

    logic [1:0] ser_data, ser_done, ser_en, accept_new, TX_OUT, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: whole frame as a bit vector plus position in it
    logic [11:0] fr   [2];
    int          flen [2];
    int          fpos [2];
    int          nstop[2];
    logic        acc_s[2];
    logic        last_tx[2];
    int          sen_cnt[2];
    int          acc_cnt[2];

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data[0]),
        .ser_done(ser_done[0]), .ser_en(ser_en[0]), .accept_new(accept_new[0]),
        .TX_OUT(TX_OUT[0]), .busy(busy[0])
    );

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data[1]),
        .ser_done(ser_done[1]), .ser_en(ser_en[1]), .accept_new(accept_new[1]),
        .TX_OUT(TX_OUT[1]), .busy(busy[1])
    );

    // Behavioural serializer: loads on acceptance, shifts LSB first on ser_en
    for (genvar g = 0; g < 2; g++) begin : g_ser
        logic [7:0] sh;
        logic [2:0] cnt;
        logic       sd, sdone;
        always @(posedge CLK or negedge RST) begin
            if (!RST) begin
                sh <= 8'h00; cnt <= 3'd0; sd <= 1'b0; sdone <= 1'b0;
            end else if (Data_Valid && accept_new[g]) begin
                sh <= P_DATA; cnt <= 3'd0; sdone <= 1'b0;
            end else if (ser_en[g]) begin
                sd    <= sh[cnt];
                cnt   <= cnt + 3'd1;
                sdone <= (cnt == 3'd7);
            end
        end
        assign ser_data[g] = sd;
        assign ser_done[g] = sdone;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_idle();
        for (int d = 0; d < 2; d++) begin
            flen[d] = 0;
            fpos[d] = 0;
        end
    endtask

    task automatic model_load(input int d);
        int n;
        fr[d] = '1;
        fr[d][0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[d][1+i] = P_DATA[i];
        n = 9;
        if (PAR_EN) begin
            fr[d][9] = 1'(($countones(P_DATA) % 2) != 0) ^ PAR_TYP;
            n = 10;
        end
        flen[d] = n + nstop[d];
        fpos[d] = 0;
    endtask

    // One bit period: compare at negedge, advance model at posedge, then release inputs
    task automatic step();
        logic b, t, s, a;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            b = (fpos[d] < flen[d]);
            t = b ? fr[d][fpos[d]] : 1'b1;
            s = b && (fpos[d] < 8);
            a = !b || (fpos[d] == flen[d] - 1);
            check($sformatf("d%0d_tx", d),     32'(TX_OUT[d]),     32'(t));
            check($sformatf("d%0d_busy", d),   32'(busy[d]),       32'(b));
            check($sformatf("d%0d_ser_en", d), 32'(ser_en[d]),     32'(s));
            check($sformatf("d%0d_accept", d), 32'(accept_new[d]), 32'(a));
            acc_s[d]   = a;
            last_tx[d] = TX_OUT[d];
            sen_cnt[d] += int'(ser_en[d]);
            acc_cnt[d] += int'(accept_new[d] && Data_Valid);
        end
        @(posedge CLK);
        for (int d = 0; d < 2; d++) begin
            if (!RST) begin
                flen[d] = 0;
                fpos[d] = 0;
            end else begin
                if (fpos[d] < flen[d]) fpos[d]++;
                if (acc_s[d] && Data_Valid) model_load(d);
            end
        end
        #1;
    endtask

    task automatic clr_counts();
        for (int d = 0; d < 2; d++) begin
            sen_cnt[d] = 0;
            acc_cnt[d] = 0;
        end
    endtask

    task automatic send(input logic [7:0] w, input logic pe, input logic pt, input int tail);
        P_DATA = w; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        // scramble config after acceptance; it must not affect the frame
        PAR_EN = ~pe; PAR_TYP = ~pt; P_DATA = ~w;
        repeat (tail) step();
    endtask

    initial begin
        logic [9:0] got;
        nstop[0] = 1;
        nstop[1] = 2;
        model_idle();
        clr_counts();

        // Reset values
        #2;
        check("rst_tx",     32'(TX_OUT),     32'(2'b11));
        check("rst_busy",   32'(busy),       32'(2'b00));
        check("rst_ser_en", 32'(ser_en),     32'(2'b00));
        check("rst_accept", 32'(accept_new), 32'(2'b11));
        repeat (2) step();
        RST = 1'b1;
        repeat (2) step();

        // Test 1: A5, no parity, explicit line pattern on the 1-stop instance
        P_DATA = 8'hA5; PAR_EN = 1'b0; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        clr_counts();
        for (int i = 0; i < 10; i++) begin
            step();
            got[i] = last_tx[0];
        end
        check("t1_frame", 32'(got), 32'(10'b1101001010));
        check("t1_ser_en_cnt", 32'(sen_cnt[0]), 32'd8);
        repeat (3) step();

        // Test 2: A5 with even then odd parity
        send(8'hA5, 1'b1, 1'b0, 13);
        send(8'hA5, 1'b1, 1'b1, 13);

        // Test 3: Data_Valid held, 00 then FF, back-to-back frames
        clr_counts();
        P_DATA = 8'h00; PAR_EN = 1'b0; Data_Valid = 1'b1;
        step();
        P_DATA = 8'hFF;
        repeat (24) step();
        Data_Valid = 1'b0;
        check("t3_accepts_d0", 32'(acc_cnt[0]), 32'd3);
        check("t3_accepts_d1", 32'(acc_cnt[1]), 32'd3);
        repeat (14) step();

        // Test 4: 81 exercising the two-stop instance
        send(8'h81, 1'b0, 1'b0, 13);

        // Test 5: Data_Valid pulse mid-DATA is ignored
        clr_counts();
        P_DATA = 8'h3C; PAR_EN = 1'b0; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        repeat (4) step();
        P_DATA = 8'hC3; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        repeat (10) step();
        check("t5_ser_en_cnt_d0", 32'(sen_cnt[0]), 32'd8);
        check("t5_ser_en_cnt_d1", 32'(sen_cnt[1]), 32'd8);
        check("t5_accepts", 32'(acc_cnt[0] + acc_cnt[1]), 32'd2);

        // Test 6: reset mid-DATA, then a fresh frame
        P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        repeat (4) step();
        RST = 1'b0;
        #1;
        check("t6_rst_tx",     32'(TX_OUT), 32'(2'b11));
        check("t6_rst_busy",   32'(busy),   32'(2'b00));
        check("t6_rst_ser_en", 32'(ser_en), 32'(2'b00));
        model_idle();
        step();
        RST = 1'b1;
        step();
        send(8'h96, 1'b1, 1'b0, 14);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            Data_Valid = ($urandom_range(0, 3) == 0);
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            step();
        end
        Data_Valid = 1'b0;
        repeat (15) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
